// File: rtl/control_decoder.sv
// control_decoder
//
// Consumer side of the button-event interface. Once per video frame it
// snapshots the sticky pressed/released flag vector and asks the collector
// to clear it. From each snapshot it updates the held-button state, picks one
// active direction with auto-repeat, and offers at most one move/action
// command per frame to player logic over a valid/ready handshake.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-low reset
//   frame_end     one-cycle pulse per video frame
//   control_state [9:5] pressed flags, [4:0] released flags
//                 (bit order UP, DOWN, LEFT, RIGHT, ACTION, LSB first)
//   clear_req     one-cycle pulse that clears the collector's flags
//   cmd_valid     command available
//   cmd_ready     player logic accepts command
//   cmd_move      command contains a move
//   cmd_dir       0=UP, 1=DOWN, 2=LEFT, 3=RIGHT
//   cmd_action    command contains an action press
//   held          current held state, same bit order as the flag fields
//   overrun       one-cycle pulse when a frame's command is dropped
module control_decoder #(
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_end,
  input  logic [9:0] control_state,
  output logic       clear_req,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_move,
  output logic [1:0] cmd_dir,
  output logic       cmd_action,
  output logic [4:0] held,
  output logic       overrun
);

  localparam logic [7:0] DELAY_LOAD = 8'(REPEAT_DELAY);
  localparam logic [7:0] RATE_LOAD  = 8'(REPEAT_RATE);

  typedef enum logic [1:0] {IDLE, CAPTURE, DECODE} state_t;

  state_t     state, next_state;
  logic [9:0] snapshot;
  logic       active_valid;
  logic [1:0] active_dir;
  logic [7:0] repeat_cnt;

  logic [4:0] pressed, released, held_next;
  logic       move_now, action_now, cmd_exists;
  logic [1:0] move_dir;
  logic       active_valid_next;
  logic [1:0] active_dir_next;
  logic [7:0] repeat_cnt_next;

  // Lowest index wins, giving UP > DOWN > LEFT > RIGHT.
  function automatic logic [1:0] pri4(input logic [3:0] v);
    logic [1:0] d;
    d = 2'd3;
    if (v[2]) d = 2'd2;
    if (v[1]) d = 2'd1;
    if (v[0]) d = 2'd0;
    return d;
  endfunction

  // The collector clears its flags on the same edge that captures them.
  assign clear_req = (state == CAPTURE);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (frame_end) next_state = CAPTURE;
      CAPTURE: next_state = DECODE;
      DECODE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Per-frame decode of the snapshot. A press and release in the same frame
  // is a tap for a button not yet held, but a release-then-repress for one
  // that was held. A tapped direction still moves once; the next frame then
  // sees it not held and falls back to whatever is still held.
  always_comb begin
    pressed           = snapshot[9:5];
    released          = snapshot[4:0];
    held_next         = (held & (pressed | ~released)) | (~held & pressed & ~released);
    move_now          = 1'b0;
    move_dir          = active_dir;
    active_valid_next = active_valid;
    active_dir_next   = active_dir;
    repeat_cnt_next   = repeat_cnt;

    if (|pressed[3:0]) begin
      active_valid_next = 1'b1;
      active_dir_next   = pri4(pressed[3:0]);
      repeat_cnt_next   = DELAY_LOAD;
      move_now          = 1'b1;
      move_dir          = pri4(pressed[3:0]);
    end else if (active_valid && held_next[active_dir]) begin
      if (repeat_cnt == 8'd1) begin
        move_now        = 1'b1;
        move_dir        = active_dir;
        repeat_cnt_next = RATE_LOAD;
      end else begin
        repeat_cnt_next = repeat_cnt - 8'd1;
      end
    end else if (|held_next[3:0]) begin
      active_valid_next = 1'b1;
      active_dir_next   = pri4(held_next[3:0]);
      repeat_cnt_next   = DELAY_LOAD;
    end else begin
      active_valid_next = 1'b0;
      active_dir_next   = 2'd0;
      repeat_cnt_next   = 8'd0;
    end

    action_now = pressed[4];
    cmd_exists = move_now | action_now;
  end

  // Snapshot, button/repeat state and the command register. A pending
  // command is never overwritten; the new one is dropped and flagged
  // instead, while held and repeat state still advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      snapshot     <= 10'd0;
      held         <= 5'd0;
      active_valid <= 1'b0;
      active_dir   <= 2'd0;
      repeat_cnt   <= 8'd0;
      cmd_valid    <= 1'b0;
      cmd_move     <= 1'b0;
      cmd_dir      <= 2'd0;
      cmd_action   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (state == CAPTURE) snapshot <= control_state;
      if (state == DECODE) begin
        held         <= held_next;
        active_valid <= active_valid_next;
        active_dir   <= active_dir_next;
        repeat_cnt   <= repeat_cnt_next;
      end
      if (state == DECODE && cmd_exists && (!cmd_valid || cmd_ready)) begin
        cmd_valid  <= 1'b1;
        cmd_move   <= move_now;
        cmd_action <= action_now;
        if (move_now) cmd_dir <= move_dir;
      end else begin
        if (state == DECODE && cmd_exists) overrun <= 1'b1;
        if (cmd_valid && cmd_ready) cmd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_control_decoder.sv
// Testbench for control_decoder: directed scenarios with literal
// expectations plus a randomized phase, all outputs compared every cycle
// against a frame-level behavioural model.
module tb_control_decoder;

  localparam int DELAY = 8;
  localparam int RATE  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_end;
  logic [9:0] control_state;
  logic       clear_req;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_move;
  logic [1:0] cmd_dir;
  logic       cmd_action;
  logic [4:0] held;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  control_decoder #(.REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)) dut (
    .clk(clk), .reset(reset), .frame_end(frame_end), .control_state(control_state),
    .clear_req(clear_req), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_move(cmd_move), .cmd_dir(cmd_dir), .cmd_action(cmd_action),
    .held(held), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Compare one value and report it if it differs.
  task automatic checkOutput(input string name, input logic [9:0] actual, input logic [9:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: tracks the cycles since an accepted frame pulse and
  // evaluates the per-frame button rules on plain integer state.
  bit         model_ok = 1'b0;
  int         stage = 0;
  logic [9:0] m_snap;
  bit         m_held[5];
  int         m_active;
  int         m_cnt;
  bit         exp_clear, exp_valid, exp_move, exp_action, exp_overrun;
  int         exp_dir;

  task automatic modelStep();
    bit p[5];
    bit r[5];
    bit nh[5];
    int np;
    int fb;
    bit mv;
    int mdir;
    bit has_cmd;
    bit hs;
    if (!reset) begin
      stage = 0; m_active = -1; m_cnt = 0;
      for (int i = 0; i < 5; i++) m_held[i] = 1'b0;
      exp_valid = 0; exp_move = 0; exp_dir = 0; exp_action = 0; exp_overrun = 0;
      model_ok = 1'b1;
    end else begin
      exp_overrun = 0;
      hs = exp_valid && cmd_ready;
      if (stage == 2) begin
        for (int i = 0; i < 5; i++) begin
          p[i] = m_snap[5+i];
          r[i] = m_snap[i];
          nh[i] = m_held[i] ? (p[i] || !r[i]) : (p[i] && !r[i]);
        end
        np = -1; fb = -1;
        for (int d = 3; d >= 0; d--) begin
          if (p[d]) np = d;
          if (nh[d]) fb = d;
        end
        mv = 0; mdir = 0;
        if (np >= 0) begin
          m_active = np; m_cnt = DELAY; mv = 1; mdir = np;
        end else if (m_active >= 0 && nh[m_active]) begin
          if (m_cnt == 1) begin mv = 1; mdir = m_active; m_cnt = RATE; end
          else m_cnt = m_cnt - 1;
        end else begin
          m_active = fb;
          m_cnt = (fb >= 0) ? DELAY : 0;
        end
        has_cmd = mv || p[4];
        if (has_cmd && (!exp_valid || cmd_ready)) begin
          exp_valid = 1; exp_move = mv; exp_action = p[4];
          if (mv) exp_dir = mdir;
        end else begin
          if (has_cmd) exp_overrun = 1;
          if (hs) exp_valid = 0;
        end
        for (int i = 0; i < 5; i++) m_held[i] = nh[i];
        stage = 0;
      end else begin
        if (hs) exp_valid = 0;
        if (stage == 1) begin m_snap = control_state; stage = 2; end
        else if (frame_end) stage = 1;
      end
    end
    exp_clear = (stage == 1);
  endtask

  always @(posedge clk) modelStep();

  function automatic logic [4:0] heldVec();
    logic [4:0] v;
    for (int i = 0; i < 5; i++) v[i] = m_held[i];
    return v;
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      checkOutput("m_clear_req", 10'(clear_req), 10'(exp_clear));
      checkOutput("m_cmd_valid", 10'(cmd_valid), 10'(exp_valid));
      checkOutput("m_cmd_move", 10'(cmd_move), 10'(exp_move));
      checkOutput("m_cmd_dir", 10'(cmd_dir), 10'(exp_dir));
      checkOutput("m_cmd_action", 10'(cmd_action), 10'(exp_action));
      checkOutput("m_held", 10'(held), 10'(heldVec()));
      checkOutput("m_overrun", 10'(overrun), 10'(exp_overrun));
    end
  end

  // One frame: pulse frame_end, keep the flags until captured, return once
  // the decode result is visible. clr reports clear_req in the capture cycle.
  task automatic applyStimulus(input logic [9:0] cs, input logic rdy, output logic clr);
    control_state = cs;
    cmd_ready = rdy;
    frame_end = 1'b1;
    @(negedge clk);
    clr = clear_req;
    frame_end = 1'b0;
    @(negedge clk);
    control_state = 10'd0;
    @(negedge clk);
  endtask

  logic clr;

  initial begin
    reset = 1'b0;
    frame_end = 1'b1;
    control_state = 10'h3FF;
    cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_clear_req", 10'(clear_req), 10'd0);
    checkOutput("rst_cmd_valid", 10'(cmd_valid), 10'd0);
    checkOutput("rst_cmd_move", 10'(cmd_move), 10'd0);
    checkOutput("rst_cmd_dir", 10'(cmd_dir), 10'd0);
    checkOutput("rst_cmd_action", 10'(cmd_action), 10'd0);
    checkOutput("rst_held", 10'(held), 10'd0);
    checkOutput("rst_overrun", 10'(overrun), 10'd0);
    reset = 1'b1;
    frame_end = 1'b0;
    control_state = 10'd0;
    @(negedge clk);
    checkOutput("post_rst_clear_req", 10'(clear_req), 10'd0);

    $display("[TB] single press");
    applyStimulus(10'b00001_00000, 1'b1, clr);
    checkOutput("press_clear_req", 10'(clr), 10'd1);
    checkOutput("press_valid", 10'(cmd_valid), 10'd1);
    checkOutput("press_move", 10'(cmd_move), 10'd1);
    checkOutput("press_dir", 10'(cmd_dir), 10'd0);
    checkOutput("press_held", 10'(held), 10'b00001);

    $display("[TB] auto-repeat");
    for (int f = 1; f <= 12; f++) begin
      applyStimulus(10'd0, 1'b1, clr);
      checkOutput($sformatf("repeat_f%0d_valid", f), 10'(cmd_valid), 10'((f == 8) || (f == 12)));
      checkOutput($sformatf("repeat_f%0d_clear", f), 10'(clr), 10'd1);
    end

    $display("[TB] press and tap");
    applyStimulus(10'b00000_00001, 1'b1, clr);
    checkOutput("release_up_held", 10'(held), 10'd0);
    applyStimulus(10'b10110_00100, 1'b1, clr);
    checkOutput("tap_valid", 10'(cmd_valid), 10'd1);
    checkOutput("tap_dir", 10'(cmd_dir), 10'd1);
    checkOutput("tap_action", 10'(cmd_action), 10'd1);
    checkOutput("tap_held", 10'(held), 10'b10010);
    applyStimulus(10'd0, 1'b1, clr);
    checkOutput("tap_next_valid", 10'(cmd_valid), 10'd0);
    applyStimulus(10'b00000_11111, 1'b1, clr);

    $display("[TB] fallback");
    applyStimulus(10'b01100_00000, 1'b1, clr);
    checkOutput("fb_press_dir", 10'(cmd_dir), 10'd2);
    applyStimulus(10'b00000_00100, 1'b1, clr);
    checkOutput("fb_release_valid", 10'(cmd_valid), 10'd0);
    checkOutput("fb_release_held", 10'(held), 10'b01000);
    for (int f = 1; f <= 8; f++) begin
      applyStimulus(10'd0, 1'b1, clr);
      checkOutput($sformatf("fb_f%0d_valid", f), 10'(cmd_valid), 10'(f == 8));
    end
    checkOutput("fb_repeat_dir", 10'(cmd_dir), 10'd3);
    applyStimulus(10'b00000_11111, 1'b1, clr);

    $display("[TB] backpressure");
    applyStimulus(10'b00001_00000, 1'b0, clr);
    checkOutput("bp_first_valid", 10'(cmd_valid), 10'd1);
    checkOutput("bp_first_dir", 10'(cmd_dir), 10'd0);
    checkOutput("bp_first_overrun", 10'(overrun), 10'd0);
    applyStimulus(10'b00010_00000, 1'b0, clr);
    checkOutput("bp_second_overrun", 10'(overrun), 10'd1);
    checkOutput("bp_second_valid", 10'(cmd_valid), 10'd1);
    checkOutput("bp_second_dir", 10'(cmd_dir), 10'd0);
    @(negedge clk);
    checkOutput("bp_overrun_pulse", 10'(overrun), 10'd0);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    checkOutput("bp_accept_valid", 10'(cmd_valid), 10'd0);
    applyStimulus(10'b00000_11111, 1'b1, clr);

    $display("[TB] random");
    for (int c = 0; c < 3000; c++) begin
      logic [9:0] cs;
      for (int i = 0; i < 10; i++) cs[i] = ($urandom_range(0, 3) == 0);
      control_state = cs;
      reset = ($urandom_range(0, 299) != 0);
      frame_end = ($urandom_range(0, 2) == 0);
      cmd_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    reset = 1'b1;
    frame_end = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
